// File: rtl/softmax_v_mac.sv
// Attention output row o[d] = sum_j p_j * V[j][d]: captures one softmax row, then runs one shared 3-stage MAC.
// Optional SOFTMAX_V_SAT_FLAG_EN adds a sticky sat_flag output.
module softmax_v_mac #(
  parameter int SOFTMAX_IN_WIDTH = 12,
  parameter int V_WIDTH          = 8,
  parameter int D_V              = 64,
  parameter int DV_ADDR_WIDTH    = $clog2(D_V),
  parameter int MAX_NUM_KEYS     = 256,
  parameter int IDX_ADDR_WIDTH   = $clog2(MAX_NUM_KEYS),
  parameter int ACC_WIDTH        = 30,
  parameter int OUT_WIDTH        = 16,
  parameter int OUT_FRAC_BITS    = 4
) (
  input  logic                               clk,
  input  logic                               rst_,
  input  logic                               start,
  input  logic [IDX_ADDR_WIDTH:0]            num_keys,
  input  logic [SOFTMAX_IN_WIDTH-1:0]        softmax_j,
  input  logic                               softmax_valid,
  input  logic [IDX_ADDR_WIDTH-1:0]          softmax_idx,
  output logic [IDX_ADDR_WIDTH-1:0]          v_key_idx,
  output logic [DV_ADDR_WIDTH-1:0]           v_dv_idx,
  input  logic signed [V_WIDTH-1:0]          v_j,
  output logic signed [OUT_WIDTH-1:0]        out_data,
  output logic [DV_ADDR_WIDTH-1:0]           out_idx,
  output logic                               out_valid,
  output logic                               busy,
  output logic                               done
`ifdef SOFTMAX_V_SAT_FLAG_EN
  ,
  output logic                               sat_flag
`endif
);

  localparam int PROD_W = SOFTMAX_IN_WIDTH + V_WIDTH + 1;
  localparam int SH     = SOFTMAX_IN_WIDTH - OUT_FRAC_BITS;
  localparam logic [IDX_ADDR_WIDTH:0]   MAX_N  = (IDX_ADDR_WIDTH+1)'(MAX_NUM_KEYS);
  localparam logic [IDX_ADDR_WIDTH:0]   ONE_N  = (IDX_ADDR_WIDTH+1)'(1);
  localparam logic [IDX_ADDR_WIDTH-1:0] ONE_K  = IDX_ADDR_WIDTH'(1);
  localparam logic [DV_ADDR_WIDTH-1:0]  ONE_D  = DV_ADDR_WIDTH'(1);
  localparam logic [DV_ADDR_WIDTH-1:0]  LAST_D = DV_ADDR_WIDTH'(D_V - 1);
  localparam logic signed [ACC_WIDTH-1:0] RND     = ACC_WIDTH'(2 ** (SH - 1));
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_COMPUTE, S_DRAIN, S_DONE} state_t;

  function automatic logic signed [ACC_WIDTH-1:0] round_acc(input logic signed [ACC_WIDTH-1:0] a);
    return (a + RND) >>> SH;
  endfunction

  function automatic logic signed [OUT_WIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] r);
    if (r > OUT_MAX)      return OUT_MAX[OUT_WIDTH-1:0];
    else if (r < OUT_MIN) return OUT_MIN[OUT_WIDTH-1:0];
    else                  return r[OUT_WIDTH-1:0];
  endfunction

  state_t                        r_state, w_next;
  logic [IDX_ADDR_WIDTH:0]       r_n, r_cap_cnt, w_n_clamp;
  logic [IDX_ADDR_WIDTH-1:0]     r_key;
  logic [DV_ADDR_WIDTH-1:0]      r_d;
  logic                          r_drain;
  logic [SOFTMAX_IN_WIDTH-1:0]   r_buf [MAX_NUM_KEYS];
  logic                          w_start_ok, w_cap, w_cap_last, w_key_last, w_issue, w_issue_last;

  logic                          vld_p1, key0_p1, last_p1, vld_p2, key0_p2, last_p2;
  logic [SOFTMAX_IN_WIDTH-1:0]   r_p_p1;
  logic [DV_ADDR_WIDTH-1:0]      r_d_p1, r_d_p2;
  logic signed [PROD_W-1:0]      w_prod_p1, r_prod_p2;
  logic signed [ACC_WIDTH-1:0]   r_acc, w_prod_ext, w_acc_next, w_round;

  assign w_start_ok   = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_n_clamp    = (num_keys > MAX_N) ? MAX_N : num_keys;
  assign w_cap        = (r_state == S_CAPTURE) && softmax_valid;
  assign w_cap_last   = w_cap && ((r_cap_cnt + ONE_N) == r_n);
  assign w_key_last   = ({1'b0, r_key} == (r_n - ONE_N));
  assign w_issue      = (r_state == S_COMPUTE);
  assign w_issue_last = w_issue && w_key_last && (r_d == LAST_D);

  assign v_key_idx = r_key;
  assign v_dv_idx  = r_d;
  assign busy      = (r_state == S_CAPTURE) || (r_state == S_COMPUTE) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_next = (w_n_clamp == '0) ? S_DONE : S_CAPTURE;
      S_CAPTURE:      if (w_cap_last) w_next = S_COMPUTE;
      S_COMPUTE:      if (w_issue_last) w_next = S_DRAIN;
      S_DRAIN:        if (r_drain) w_next = S_DONE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Address generation: key is the inner loop so one d completes every N cycles.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_n       <= '0;
      r_cap_cnt <= '0;
      r_key     <= '0;
      r_d       <= '0;
      r_drain   <= 1'b0;
    end else begin
      r_drain <= (r_state == S_DRAIN);
      if (w_start_ok) begin
        r_n       <= w_n_clamp;
        r_cap_cnt <= '0;
        r_key     <= '0;
        r_d       <= '0;
      end
      if (w_cap) r_cap_cnt <= r_cap_cnt + ONE_N;
      if (w_issue) begin
        if (w_key_last) begin
          r_key <= '0;
          r_d   <= (r_d == LAST_D) ? '0 : r_d + ONE_D;
        end else begin
          r_key <= r_key + ONE_K;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_cap) r_buf[softmax_idx] <= softmax_j;
  end

  // Stage p1: weight and V element available
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      vld_p1  <= 1'b0;
      key0_p1 <= 1'b0;
      last_p1 <= 1'b0;
      vld_p2  <= 1'b0;
      key0_p2 <= 1'b0;
      last_p2 <= 1'b0;
    end else begin
      vld_p1  <= w_issue;
      key0_p1 <= (r_key == '0);
      last_p1 <= w_key_last;
      vld_p2  <= vld_p1;
      key0_p2 <= key0_p1;
      last_p2 <= last_p1;
    end
  end

  always_ff @(posedge clk) begin
    r_p_p1    <= r_buf[r_key];
    r_d_p1    <= r_d;
    r_prod_p2 <= w_prod_p1;
    r_d_p2    <= r_d_p1;
  end

  assign w_prod_p1 = PROD_W'($signed({1'b0, r_p_p1})) * PROD_W'(v_j);

  // Stage p2: accumulate; a key-0 product restarts the sum for a new d
  assign w_prod_ext = ACC_WIDTH'(r_prod_p2);
  assign w_acc_next = key0_p2 ? w_prod_ext : r_acc + w_prod_ext;
  assign w_round    = round_acc(w_acc_next);

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      out_valid <= vld_p2 && last_p2;
      if (vld_p2) r_acc <= w_acc_next;
      if (vld_p2 && last_p2) begin
        out_data <= sat_out(w_round);
        out_idx  <= r_d_p2;
      end
    end
  end

`ifdef SOFTMAX_V_SAT_FLAG_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)           sat_flag <= 1'b0;
    else if (w_start_ok) sat_flag <= 1'b0;
    else if (vld_p2 && last_p2 && (w_round > OUT_MAX || w_round < OUT_MIN)) sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_softmax_v_mac.sv
// Bench for softmax_v_mac: vector table of whole rows plus hand sequences for reset, restart and timing.
// Exercises sat_flag when SOFTMAX_V_SAT_FLAG_EN is defined.
module tb_softmax_v_mac;
  localparam int D_V = 64;

  logic clk = 1'b0, rst_ = 1'b0, start = 1'b0, softmax_valid = 1'b0;
  logic [8:0]  num_keys = '0;
  logic [11:0] softmax_j = '0;
  logic [7:0]  softmax_idx = '0;
  logic [7:0]  v_key_idx;
  logic [5:0]  v_dv_idx;
  logic signed [7:0]  v_j = '0;
  logic signed [15:0] out_data;
  logic [5:0]  out_idx;
  logic        out_valid, busy, done;
`ifdef SOFTMAX_V_SAT_FLAG_EN
  logic        sat_flag;
`endif

  softmax_v_mac dut (
    .clk(clk), .rst_(rst_), .start(start), .num_keys(num_keys),
    .softmax_j(softmax_j), .softmax_valid(softmax_valid), .softmax_idx(softmax_idx),
    .v_key_idx(v_key_idx), .v_dv_idx(v_dv_idx), .v_j(v_j),
    .out_data(out_data), .out_idx(out_idx), .out_valid(out_valid),
    .busy(busy), .done(done)
`ifdef SOFTMAX_V_SAT_FLAG_EN
    , .sat_flag(sat_flag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int data; } sb_t;
  typedef struct { int nk; int p; int vb; int vd; int vj; int perm; int idx; int exp; int sat; } vec_t;

  sb_t sb[$];
  sb_t m_e;
  logic signed [7:0] vmem [256][64];
  int pbuf [256];
  int got [64];
  int pulses = 0;
  int total = 0, bad = 0;

  // External V memory: one-cycle read latency
  always @(posedge clk) v_j <= vmem[v_key_idx][v_dv_idx];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      got[out_idx] = out_data;
      if (sb.size() == 0) check("unexpected_out_valid", 1, 0);
      else begin
        m_e = sb.pop_front();
        check("out_idx", out_idx, m_e.idx);
        check("out_data", out_data, m_e.data);
      end
    end
  end

  function automatic int model(input int nk, input int d);
    longint acc = 0;
    longint r;
    for (int j = 0; j < nk; j++) acc += longint'(pbuf[j]) * longint'(vmem[j][d]);
    r = (acc + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  task automatic run_row(input int nk, input int p, input int vb, input int vd, input int vj,
                         input int perm, input int gap, input int chk_seq, input int poke, input int abort);
    int order [4] = '{3, 1, 0, 2};
    int cnt, idx, pn, budget;
    budget = nk * D_V + 40;
    for (int j = 0; j < nk; j++)
      for (int d = 0; d < D_V; d++) vmem[j][d] = 8'(vb + vd * d + vj * j);
    for (int j = 0; j < nk; j++) pbuf[j] = p;
    for (int d = 0; d < D_V; d++) got[d] = 100000;
    pulses = 0;
    @(negedge clk); start = 1'b1; num_keys = 9'(nk);
    for (int d = 0; d < D_V; d++) sb.push_back('{d, model(nk, d)});
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < nk; i++) begin
      idx = (perm != 0) ? order[i] : i;
      @(negedge clk); softmax_valid = 1'b1; softmax_idx = 8'(idx); softmax_j = 12'(p);
      if (gap > 0 && i != nk - 1) begin
        @(negedge clk); softmax_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk); softmax_valid = 1'b0;
    cnt = 1;
    forever begin
      if (chk_seq != 0 && cnt <= 4) begin
        check("v_key_idx_seq", v_key_idx, (cnt - 1) % 3);
        check("v_dv_idx_seq", v_dv_idx, (cnt - 1) / 3);
      end
      if (cnt == poke) begin start = 1'b1; num_keys = 9'd5; end
      else start = 1'b0;
      if (cnt == abort) begin
        rst_ = 1'b0;
        #1;
        pn = pulses;
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_idx", out_idx, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_v_addr", {v_key_idx, v_dv_idx}, 0);
        sb.delete();
        @(negedge clk); rst_ = 1'b1;
        repeat (20) @(negedge clk);
        check("no_pulse_after_abort", pulses, pn);
        check("idle_after_abort", {busy, done}, 0);
        return;
      end
      if (done) break;
      if (cnt >= budget) begin
        check("done_timeout", 0, 1);
        break;
      end
      @(negedge clk); cnt++;
    end
    check("done_cycles", cnt, nk * D_V + 3);
    check("last_out_valid_at_done", out_valid, 1);
    check("last_out_idx_at_done", out_idx, D_V - 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("pulse_count", pulses, D_V);
    check("scoreboard_empty", sb.size(), 0);
  endtask

  vec_t vt [6];
  int bz;

  initial begin
    vt[0] = '{1,   4095, -32,  1, 0, 0, 42,    160, 0};
    vt[1] = '{1,   4095, -32,  1, 0, 0,  0,   -512, 0};
    vt[2] = '{4,   1024,   8,  0, 8, 0,  0,    320, 0};
    vt[3] = '{4,   1024,   8,  0, 8, 1,  0,    320, 0};
    vt[4] = '{256, 4095, 127,  0, 0, 0,  5,  32767, 1};
    vt[5] = '{256, 4095, -128, 0, 0, 0, 63, -32768, 1};

    repeat (3) @(negedge clk);
    check("reset_out", {out_valid, busy, done, out_idx, v_key_idx, v_dv_idx}, 0);
    check("reset_out_data", out_data, 0);
`ifdef SOFTMAX_V_SAT_FLAG_EN
    check("reset_sat_flag", sat_flag, 0);
`endif
    rst_ = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 6; r++) begin
      run_row(vt[r].nk, vt[r].p, vt[r].vb, vt[r].vd, vt[r].vj, vt[r].perm, 0, 0, -1, -1);
      check($sformatf("spot%0d", r), got[vt[r].idx], vt[r].exp);
`ifdef SOFTMAX_V_SAT_FLAG_EN
      check($sformatf("sat_flag%0d", r), sat_flag, vt[r].sat);
`endif
    end

    // Accepted start from DONE with zero keys clears sat_flag and stays done
    @(negedge clk); start = 1'b1; num_keys = 9'd0;
    @(negedge clk); start = 1'b0;
    check("zero_keys_from_done", done, 1);
`ifdef SOFTMAX_V_SAT_FLAG_EN
    check("sat_flag_cleared", sat_flag, 0);
`endif

    // Zero keys from IDLE: done next cycle, never busy, no output
    rst_ = 1'b0;
    @(negedge clk); rst_ = 1'b1;
    @(negedge clk);
    check("idle_done_low", done, 0);
    pulses = 0;
    start = 1'b1; num_keys = 9'd0;
    @(negedge clk); start = 1'b0;
    check("zero_keys_done", done, 1);
    bz = busy ? 1 : 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) bz++;
    end
    check("zero_keys_busy", bz, 0);
    check("zero_keys_pulses", pulses, 0);

    // Start during COMPUTE ignored; then reset mid-COMPUTE; then a clean row
    run_row(2, 2000, 5, 1, -3, 0, 0, 0, 10, -1);
    run_row(2, 2000, 5, 1, -3, 0, 0, 0, -1, 30);
    run_row(2, 3000, -7, 2, 1, 0, 0, 0, -1, -1);

    // Gapped capture, address order and total latency
    run_row(3, 1365, 10, -1, 4, 0, 2, 1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
